// File: rtl/bist_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bist_scheduler
//  Brief    : MBIST sequencer. Starts one memory BIST controller at a time,
//             waits for its done, records pass/fail and watchdog expiry, and
//             reports an aggregate done with per-memory fail/timeout vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module bist_scheduler #(
   parameter int N_MEM   = 4,
   parameter int IDX_W   = 2,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic             bist_clk,
   input  logic             bist_rst_n,
   input  logic             sched_start,
   input  logic [N_MEM-1:0] mem_en,
   input  logic [N_MEM-1:0] mem_done,
   input  logic [N_MEM-1:0] mem_fail,
   output logic [N_MEM-1:0] mem_start,
   output logic [IDX_W-1:0] cur_idx,
   output logic             sched_busy,
   output logic             sched_done,
   output logic [N_MEM-1:0] fail_vec,
   output logic [N_MEM-1:0] timeout_vec
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEL     = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_MEM - 1);
   localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
   localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0]  c_to_one   = TO_W'(1);

   logic [2:0]       r_state;
   logic [2:0]       w_next_state;
   logic [IDX_W-1:0] r_idx;
   logic [TO_W-1:0]  r_timer;
   logic [N_MEM-1:0] r_mask;
   logic [N_MEM-1:0] r_fail_vec;
   logic [N_MEM-1:0] r_timeout_vec;

   logic w_sel_en;
   logic w_sel_done;
   logic w_is_last;
   logic w_wd_expired;

   // Only the currently indexed controller is ever looked at.
   assign w_sel_en     = r_mask[r_idx];
   assign w_sel_done   = mem_done[r_idx];
   assign w_is_last    = (r_idx == c_last_idx);
   assign w_wd_expired = (r_timer == c_to_last);

   assign cur_idx     = r_idx;
   assign fail_vec    = r_fail_vec;
   assign timeout_vec = r_timeout_vec;

   // State register
   always_ff @(posedge bist_clk or negedge bist_rst_n) begin
      if (!bist_rst_n) r_state <= S_IDLE;
      else             r_state <= w_next_state;
   end

   // Next-state decode; done takes priority over watchdog expiry in RUN
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (sched_start) w_next_state = S_SEL;
         S_SEL: begin
            if (w_sel_en)       w_next_state = S_RUN;
            else if (w_is_last) w_next_state = S_DONE;
         end
         S_RUN:     if (w_sel_done || w_wd_expired) w_next_state = S_RELEASE;
         S_RELEASE: if (!w_sel_done) w_next_state = w_is_last ? S_DONE : S_SEL;
         S_DONE:    if (!sched_start) w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Datapath: mask latch, index walk, watchdog timer and result vectors
   always_ff @(posedge bist_clk or negedge bist_rst_n) begin
      if (!bist_rst_n) begin
         r_idx         <= '0;
         r_timer       <= '0;
         r_mask        <= '0;
         r_fail_vec    <= '0;
         r_timeout_vec <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sched_start) begin
                  r_mask        <= mem_en;
                  r_fail_vec    <= '0;
                  r_timeout_vec <= '0;
                  r_idx         <= '0;
               end
            end
            S_SEL: begin
               if (w_sel_en)        r_timer <= '0;
               else if (!w_is_last) r_idx   <= r_idx + c_idx_one;
            end
            S_RUN: begin
               if (w_sel_done) begin
                  r_fail_vec[r_idx] <= mem_fail[r_idx];
               end else if (w_wd_expired) begin
                  r_fail_vec[r_idx]    <= 1'b1;
                  r_timeout_vec[r_idx] <= 1'b1;
               end else begin
                  r_timer <= r_timer + c_to_one;
               end
            end
            S_RELEASE: begin
               if (!w_sel_done && !w_is_last) r_idx <= r_idx + c_idx_one;
            end
            default: ;
         endcase
      end
   end

   // Output decode from state and the registered index only
   always_comb begin
      mem_start  = '0;
      sched_busy = 1'b0;
      sched_done = 1'b0;
      case (r_state)
         S_SEL:     sched_busy = 1'b1;
         S_RUN: begin
            sched_busy       = 1'b1;
            mem_start[r_idx] = 1'b1;
         end
         S_RELEASE: sched_busy = 1'b1;
         S_DONE:    sched_done = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire
